// File: rtl/atm_pkg.sv
// Shared ATM definitions: PIN verifier states and defaults, plus the
// card controller's state constants.
package atm_pkg;

  localparam int PIN_DIGITS_DEF     = 4;
  localparam int MAX_ATTEMPTS_DEF   = 3;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    PV_IDLE    = 3'd0,
    PV_COLLECT = 3'd1,
    PV_CHECK   = 3'd2,
    PV_GRANTED = 3'd3,
    PV_LOCKED  = 3'd4
  } pv_state_t;

  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_CARD_WAIT = 3'd1,
    CTRL_PIN_ENTRY = 3'd2,
    CTRL_MENU      = 3'd3,
    CTRL_EJECT     = 3'd4
  } ctrl_state_t;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_timer.sv
// Idle timer for PIN entry: down-counter reloaded on clear, flags the
// terminal count for exactly one cycle while enabled.
module pin_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= LOAD;
    end else if (clear) begin
      r_count <= LOAD;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Clear wins, so any accepted key in the terminal cycle suppresses expiry.
  assign expired = enable && !clear && (r_count == '0);

endmodule

// File: rtl/pin_verifier.sv
// PIN verifier: collects BCD digits, compares against the stored PIN,
// counts wrong attempts and retains the card after too many.
//
// state      | meaning
// IDLE       | no card, waiting for card_in
// COLLECT    | card present, gathering digits
// CHECK      | one-cycle compare of buffer against stored_pin
// GRANTED    | PIN accepted, session open until card removed
// LOCKED     | attempts exhausted, card retained until reset
module pin_verifier
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = PIN_DIGITS_DEF,
  parameter int MAX_ATTEMPTS   = MAX_ATTEMPTS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    card_in,
  input  logic                    key_valid,
  input  logic [3:0]              key_digit,
  input  logic                    key_enter,
  input  logic                    key_clear,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  output logic                    pin_ok,
  output logic                    pin_fail,
  output logic                    timeout,
  output logic                    session_active,
  output logic                    card_retained,
  output logic [1:0]              attempts_left,
  output logic [2:0]              digit_count
);

  localparam int BW = 4 * PIN_DIGITS;
  localparam logic [2:0] FULL = 3'(PIN_DIGITS);
  localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

  pv_state_t     r_state;
  logic [BW-1:0] r_buffer;
  logic [2:0]    r_digit_count;
  logic [1:0]    r_attempts;
  logic          r_pin_ok;
  logic          r_pin_fail;
  logic          r_timeout;
  logic          r_session;
  logic          r_retained;

  logic w_digit_ok;
  logic w_restart;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_expired;

  assign w_digit_ok = key_valid && is_bcd(key_digit) && (r_digit_count < FULL);
  assign w_restart  = (r_state == PV_COLLECT) && card_in &&
                      (key_clear || key_enter || w_digit_ok);
  assign w_timer_en    = (r_state == PV_COLLECT);
  assign w_timer_clear = (r_state != PV_COLLECT) || w_restart;

  pin_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_timer_clear),
    .enable (w_timer_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= PV_IDLE;
      r_buffer      <= '0;
      r_digit_count <= '0;
      r_attempts    <= MAX_ATT;
      r_pin_ok      <= 1'b0;
      r_pin_fail    <= 1'b0;
      r_timeout     <= 1'b0;
      r_session     <= 1'b0;
      r_retained    <= 1'b0;
    end else begin
      r_pin_ok   <= 1'b0;
      r_pin_fail <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        PV_IDLE: begin
          if (card_in) begin
            r_state       <= PV_COLLECT;
            r_buffer      <= '0;
            r_digit_count <= '0;
            r_attempts    <= MAX_ATT;
          end
        end
        PV_COLLECT: begin
          if (!card_in) begin
            r_state       <= PV_IDLE;
            r_buffer      <= '0;
            r_digit_count <= '0;
          end else if (key_clear) begin
            r_buffer      <= '0;
            r_digit_count <= '0;
          end else if (key_enter) begin
            if (r_digit_count == FULL) begin
              r_state <= PV_CHECK;
            end else begin
              r_buffer      <= '0;
              r_digit_count <= '0;
              if (r_attempts <= 2'd1) begin
                r_attempts <= 2'd0;
                r_state    <= PV_LOCKED;
                r_retained <= 1'b1;
              end else begin
                r_attempts <= r_attempts - 2'd1;
                r_pin_fail <= 1'b1;
              end
            end
          end else if (w_digit_ok) begin
            r_buffer      <= {r_buffer[BW-5:0], key_digit};
            r_digit_count <= r_digit_count + 3'd1;
          end else if (w_expired) begin
            r_timeout     <= 1'b1;
            r_state       <= PV_IDLE;
            r_buffer      <= '0;
            r_digit_count <= '0;
          end
        end
        PV_CHECK: begin
          // The entered PIN is never kept once the compare is done.
          r_buffer      <= '0;
          r_digit_count <= '0;
          if (!card_in) begin
            r_state <= PV_IDLE;
          end else if (r_buffer == stored_pin) begin
            r_state   <= PV_GRANTED;
            r_pin_ok  <= 1'b1;
            r_session <= 1'b1;
          end else if (r_attempts <= 2'd1) begin
            r_attempts <= 2'd0;
            r_state    <= PV_LOCKED;
            r_retained <= 1'b1;
          end else begin
            r_attempts <= r_attempts - 2'd1;
            r_pin_fail <= 1'b1;
            r_state    <= PV_COLLECT;
          end
        end
        PV_GRANTED: begin
          if (!card_in) begin
            r_state   <= PV_IDLE;
            r_session <= 1'b0;
          end
        end
        PV_LOCKED: begin
          r_retained <= 1'b1;
        end
        default: begin
          r_state <= PV_IDLE;
        end
      endcase
    end
  end

  assign pin_ok         = r_pin_ok;
  assign pin_fail       = r_pin_fail;
  assign timeout        = r_timeout;
  assign session_active = r_session;
  assign card_retained  = r_retained;
  assign attempts_left  = r_attempts;
  assign digit_count    = r_digit_count;

endmodule

// File: tb/tb_pin_verifier.sv
// Directed, table-driven bench for pin_verifier with hand-computed
// expectations (stored PIN 1234, three attempts, 16-cycle idle timeout).
module tb_pin_verifier;

  logic        clk = 1'b0;
  logic        reset;
  logic        card_in;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_enter;
  logic        key_clear;
  logic [15:0] stored_pin;
  logic        pin_ok;
  logic        pin_fail;
  logic        timeout;
  logic        session_active;
  logic        card_retained;
  logic [1:0]  attempts_left;
  logic [2:0]  digit_count;

  int n_vec = 0;
  int n_err = 0;

  pin_verifier #(
    .PIN_DIGITS(4),
    .MAX_ATTEMPTS(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .card_in       (card_in),
    .key_valid     (key_valid),
    .key_digit     (key_digit),
    .key_enter     (key_enter),
    .key_clear     (key_clear),
    .stored_pin    (stored_pin),
    .pin_ok        (pin_ok),
    .pin_fail      (pin_fail),
    .timeout       (timeout),
    .session_active(session_active),
    .card_retained (card_retained),
    .attempts_left (attempts_left),
    .digit_count   (digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       card;
    logic       kv;
    logic [3:0] dig;
    logic       ent;
    logic       clr;
    logic       ok;
    logic       fail;
    logic       to;
    logic       sess;
    logic       ret;
    logic [1:0] att;
    logic [2:0] dc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, kv, input logic [3:0] d, input logic e, cl,
                     input logic ok, fl, to, se, rt, input logic [1:0] at,
                     input logic [2:0] dc);
    vec_t v;
    v.card = c; v.kv = kv; v.dig = d; v.ent = e; v.clr = cl;
    v.ok = ok; v.fail = fl; v.to = to; v.sess = se; v.ret = rt;
    v.att = at; v.dc = dc;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic c, kv, input logic [3:0] d, input logic e, cl);
    card_in = c; key_valid = kv; key_digit = d; key_enter = e; key_clear = cl;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
  endtask

  task automatic chk(input string name, input logic ok, fl, to, se, rt,
                     input logic [1:0] at, input logic [2:0] dc);
    logic [9:0] act, exp;
    act = {pin_ok, pin_fail, timeout, session_active, card_retained,
           attempts_left, digit_count};
    exp = {ok, fl, to, se, rt, at, dc};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ok/fail/to/sess/ret/att/dc=%b/%b/%b/%b/%b/%0d/%0d want %b/%b/%b/%b/%b/%0d/%0d",
               name, act[9], act[8], act[7], act[6], act[5], act[4:3], act[2:0],
               exp[9], exp[8], exp[7], exp[6], exp[5], exp[4:3], exp[2:0]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("async_reset", 0, 0, 0, 0, 0, 2'd3, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; card_in = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    key_enter = 1'b0; key_clear = 1'b0; stored_pin = 16'h1234;
    #1;
    chk("reset_values", 0, 0, 0, 0, 0, 2'd3, 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // card kv dig ent clr | ok fail to sess ret att dc
    add(1,0,4'd0,0,0, 0,0,0,0,0,3,0);   // IDLE -> COLLECT
    add(1,1,4'd1,0,0, 0,0,0,0,0,3,1);
    add(1,1,4'd2,0,0, 0,0,0,0,0,3,2);
    add(1,1,4'd3,0,0, 0,0,0,0,0,3,3);
    add(1,1,4'd4,0,0, 0,0,0,0,0,3,4);
    add(1,0,4'd0,1,0, 0,0,0,0,0,3,4);   // enter sampled -> CHECK
    add(1,0,4'd0,0,0, 1,0,0,1,0,3,0);   // pin_ok 2 edges after enter
    add(1,0,4'd0,0,0, 0,0,0,1,0,3,0);   // single-cycle pulse
    add(0,0,4'd0,0,0, 0,0,0,0,0,3,0);   // card out -> IDLE
    add(1,0,4'd0,0,0, 0,0,0,0,0,3,0);
    add(1,1,4'd1,0,0, 0,0,0,0,0,3,1);
    add(1,1,4'd2,0,0, 0,0,0,0,0,3,2);
    add(1,1,4'd9,0,0, 0,0,0,0,0,3,3);
    add(1,0,4'd0,0,1, 0,0,0,0,0,3,0);   // clear
    add(1,1,4'd1,0,0, 0,0,0,0,0,3,1);
    add(1,1,4'd2,0,0, 0,0,0,0,0,3,2);
    add(1,1,4'hA,0,0, 0,0,0,0,0,3,2);   // non-BCD ignored
    add(1,1,4'd3,0,0, 0,0,0,0,0,3,3);
    add(1,1,4'd4,0,0, 0,0,0,0,0,3,4);
    add(1,1,4'd5,0,0, 0,0,0,0,0,3,4);   // fifth digit ignored
    add(1,0,4'd0,1,0, 0,0,0,0,0,3,4);
    add(1,0,4'd0,0,0, 1,0,0,1,0,3,0);
    add(0,0,4'd0,0,0, 0,0,0,0,0,3,0);
    add(1,0,4'd0,0,0, 0,0,0,0,0,3,0);
    add(1,1,4'd1,0,0, 0,0,0,0,0,3,1);
    add(1,1,4'd2,0,0, 0,0,0,0,0,3,2);
    add(1,0,4'd0,1,0, 0,1,0,0,0,2,0);   // short entry -> fail
    add(1,0,4'd0,0,0, 0,0,0,0,0,2,0);

    foreach (tbl[i]) begin
      step(tbl[i].card, tbl[i].kv, tbl[i].dig, tbl[i].ent, tbl[i].clr);
      chk($sformatf("tbl[%0d]", i), tbl[i].ok, tbl[i].fail, tbl[i].to,
          tbl[i].sess, tbl[i].ret, tbl[i].att, tbl[i].dc);
    end

    // Lockout after three wrong PINs; LOCKED ignores card removal and keys.
    do_reset();
    step(1, 0, 4'd0, 0, 0);
    for (int a = 0; a < 3; a++) begin
      step(1, 1, 4'd1, 0, 0);
      step(1, 1, 4'd2, 0, 0);
      step(1, 1, 4'd3, 0, 0);
      step(1, 1, 4'd5, 0, 0);
      step(1, 0, 4'd0, 1, 0);
      chk($sformatf("lock_enter%0d", a), 0, 0, 0, 0, 0, 2'(3 - a), 3'd4);
      step(1, 0, 4'd0, 0, 0);
      if (a < 2) chk($sformatf("lock_fail%0d", a), 0, 1, 0, 0, 0, 2'(2 - a), 3'd0);
      else       chk("lock_final", 0, 0, 0, 0, 1, 2'd0, 3'd0);
    end
    step(0, 0, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 0);
    chk("lock_card_out", 0, 0, 0, 0, 1, 2'd0, 3'd0);
    step(1, 1, 4'd1, 0, 0);
    step(1, 0, 4'd0, 1, 0);
    chk("lock_keys", 0, 0, 0, 0, 1, 2'd0, 3'd0);
    do_reset();

    // Timeout: one digit then 16 idle cycles.
    step(1, 0, 4'd0, 0, 0);
    step(1, 1, 4'd7, 0, 0);
    for (int k = 1; k <= 15; k++) step(1, 0, 4'd0, 0, 0);
    chk("timeout_before", 0, 0, 0, 0, 0, 2'd3, 3'd1);
    step(1, 0, 4'd0, 0, 0);
    chk("timeout_pulse", 0, 0, 1, 0, 0, 2'd3, 3'd0);
    step(0, 0, 4'd0, 0, 0);
    chk("timeout_once", 0, 0, 0, 0, 0, 2'd3, 3'd0);

    // Simultaneous strobes with four digits buffered: clear wins.
    do_reset();
    step(1, 0, 4'd0, 0, 0);
    step(1, 1, 4'd1, 0, 0);
    step(1, 1, 4'd2, 0, 0);
    step(1, 1, 4'd3, 0, 0);
    step(1, 1, 4'd4, 0, 0);
    card_in = 1'b1; key_valid = 1'b1; key_digit = 4'd5; key_enter = 1'b1; key_clear = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    chk("simul_clear", 0, 0, 0, 0, 0, 2'd3, 3'd0);
    step(1, 0, 4'd0, 0, 0);
    chk("simul_no_check", 0, 0, 0, 0, 0, 2'd3, 3'd0);
    step(1, 1, 4'd1, 0, 0);
    step(1, 1, 4'd2, 0, 0);
    step(1, 1, 4'd3, 0, 0);
    step(1, 1, 4'd4, 0, 0);
    step(1, 0, 4'd0, 1, 0);
    step(1, 0, 4'd0, 0, 0);
    chk("simul_still_collect", 1, 0, 0, 1, 0, 2'd3, 3'd0);

    // Asynchronous reset mid-COLLECT, after one wrong attempt and two digits.
    do_reset();
    step(1, 0, 4'd0, 0, 0);
    step(1, 1, 4'd1, 0, 0);
    step(1, 0, 4'd0, 1, 0);
    chk("short_fail", 0, 1, 0, 0, 0, 2'd2, 3'd0);
    step(1, 1, 4'd1, 0, 0);
    step(1, 1, 4'd2, 0, 0);
    chk("pre_reset", 0, 0, 0, 0, 0, 2'd2, 3'd2);
    do_reset();

    // Card removal after three digits.
    step(1, 0, 4'd0, 0, 0);
    step(1, 1, 4'd1, 0, 0);
    step(1, 1, 4'd2, 0, 0);
    step(1, 1, 4'd3, 0, 0);
    chk("pre_remove", 0, 0, 0, 0, 0, 2'd3, 3'd3);
    step(0, 0, 4'd0, 0, 0);
    chk("card_removed", 0, 0, 0, 0, 0, 2'd3, 3'd0);
    step(0, 0, 4'd0, 0, 0);
    chk("card_removed_quiet", 0, 0, 0, 0, 0, 2'd3, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pin_verifier.md
PIN_VERIFIER -- requirements
Module: pin_verifier

Interface
REQ-001 Parameters SHALL be, one per line:
- PIN_DIGITS, 4, number of BCD digits per PIN.
- MAX_ATTEMPTS, 3, wrong entries allowed before lock.
- TIMEOUT_CYCLES, 1024, idle cycles in COLLECT before abandon.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- card_in  in  1  card present (level).
- key_valid  in  1  one-cycle keypad digit strobe.
- key_digit  in  4  BCD digit, qualified by key_valid.
- key_enter  in  1  one-cycle enter strobe.
- key_clear  in  1  one-cycle clear strobe.
- stored_pin  in  16  reference PIN; digit 1 is in [15:12].
- pin_ok  out  1  one-cycle pulse on correct PIN; drives the controller's pin_entry.
- pin_fail  out  1  one-cycle pulse per wrong attempt.
- timeout  out  1  one-cycle pulse on entry abandon.
- session_active  out  1  level, high while GRANTED.
- card_retained  out  1  level, high while LOCKED.
- attempts_left  out  2  remaining attempts.
- digit_count  out  3  digits currently buffered.

Function
REQ-003 The FSM SHALL have the states IDLE, COLLECT, CHECK, GRANTED and LOCKED; all outputs SHALL be registered.
REQ-004 In IDLE with card_in=1, the FSM SHALL go to COLLECT next edge, with buffer=0, digit_count=0, attempts_left=MAX_ATTEMPTS and the timer cleared.
REQ-005 In COLLECT, a key_valid with key_digit<=9 and digit_count<PIN_DIGITS SHALL shift buffer <= {buffer[11:0],key_digit} and increment digit_count.
REQ-006 Digits greater than 9, and digits arriving when digit_count==PIN_DIGITS, SHALL be ignored: no shift, no count change, and no timer restart.
REQ-007 key_clear SHALL zero buffer and digit_count and stay in COLLECT.
REQ-008 When strobes coincide, priority SHALL be card removal > key_clear > key_enter > key_valid; lower-priority strobes in that cycle SHALL be dropped.
REQ-009 key_enter with digit_count==PIN_DIGITS SHALL go to CHECK.
REQ-010 key_enter with digit_count<PIN_DIGITS SHALL be a wrong attempt, handled as in REQ-012 without entering CHECK.
REQ-011 CHECK SHALL last exactly one cycle; on buffer==stored_pin it SHALL go to GRANTED and pulse pin_ok for one cycle. pin_ok SHALL be high in the cycle following the second rising edge after key_enter is sampled.
REQ-012 On a wrong attempt, attempts_left SHALL decrement.
- If the result is 0: go to LOCKED, with no pin_fail pulse.
- Otherwise: pulse pin_fail for one cycle, clear buffer and digit_count, and return to COLLECT.
REQ-013 The timer SHALL count cycles in COLLECT and restart on any accepted key_valid, key_clear or key_enter. On reaching TIMEOUT_CYCLES it SHALL pulse timeout and go to IDLE, clearing buffer and digit_count.
REQ-014 GRANTED SHALL hold session_active=1 until card_in=0, then go to IDLE.
REQ-015 card_in=0 in COLLECT or CHECK SHALL go to IDLE with no pin_ok, pin_fail or timeout pulse.
REQ-016 LOCKED SHALL hold card_retained=1, ignore all inputs including card_in, and exit only on reset.
REQ-017 stored_pin SHALL be sampled only in CHECK; changes at other times SHALL have no effect.
REQ-018 attempts_left SHALL never underflow, and digit_count SHALL never exceed PIN_DIGITS.

Reset
REQ-019 On reset=1, immediately and independent of clk, the block SHALL force:
- state=IDLE, buffer=0, timer=0.
- pin_ok=0, pin_fail=0, timeout=0, session_active=0, card_retained=0.
- attempts_left=MAX_ATTEMPTS, digit_count=0.
REQ-020 Reset asserted mid-operation, in any state including LOCKED, SHALL discard any partial entry; the first active edge after release SHALL evaluate from IDLE.

Structure
REQ-021 The state enumeration, PIN_DIGITS, MAX_ATTEMPTS and TIMEOUT_CYCLES defaults SHALL live in the shared package atm_pkg, alongside the controller's state constants.
REQ-022 The idle timer SHALL be one sub-module, pin_timer, with inputs clear and enable and a single-cycle expired output.

Verification (stored_pin=16'h1234, MAX_ATTEMPTS=3)
REQ-023 The bench SHALL cover the following directed scenarios:
- Correct entry: card_in=1, keys 1,2,3,4, enter -> pin_ok high for exactly 1 cycle, 2 edges after enter; session_active=1; attempts_left=3.
- Lockout: card_in=1, then three times keys 1,2,3,5 + enter -> pin_fail pulses with attempts_left 2 then 1; third attempt gives card_retained=1, attempts_left=0, pin_ok never asserts; card_in=0 does not exit LOCKED.
- Clear and invalid digits: keys 1,2,9, clear, 1,2,3,4 with 4'hA injected, enter -> digit 4'hA ignored, pin_ok pulses; short entry 1,2 + enter -> pin_fail and attempts_left 2.
- Timeout (TIMEOUT_CYCLES=16): card_in=1, key 7, then 16 idle cycles -> timeout pulses once, state IDLE, digit_count=0.
- Simultaneous strobes: key_clear, key_enter and key_valid in the same cycle with 4 digits buffered -> clear wins, digit_count=0, no CHECK.
- Reset and card removal: reset mid-COLLECT after 2 digits -> all outputs at reset values with no clock edge; card_in dropped after 3 digits -> IDLE with no pulse outputs.
